// File: rtl/cnn_layer_accel_pfb_rd_seq.sv
// Read sequencer for the prefetch buffer: walks one expanded input map in raster
// order, pacing each row on row_avail from the fetch side or on cncl_fetch_req.
module cnn_layer_accel_pfb_rd_seq #(
    parameter int C_CLG2_ROW_BUF_BRAM_DEPTH = 10
) (
    input  logic                                 rd_clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] num_cols,
    input  logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] num_rows,
    input  logic                                 row_avail,
    input  logic                                 cncl_fetch_req,
    input  logic                                 stall,
    input  logic                                 abort,
    output logic                                 rd_en,
    output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] input_col,
    output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] input_row,
    output logic                                 next_row,
    output logic                                 rst_addr,
    output logic                                 row_ack,
    output logic                                 job_done,
    output logic                                 busy
);

    localparam int W = C_CLG2_ROW_BUF_BRAM_DEPTH;
    localparam logic [W-1:0] ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROW,
        S_READ_ROW,
        S_ROW_END,
        S_DONE
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_num_cols, r_num_rows, w_num_cols_nxt, w_num_rows_nxt;
    logic [W-1:0] r_col, r_row, w_col_nxt, w_row_nxt;
    logic         r_row_end, r_row_ack, r_job_done, r_busy;
    logic         w_row_ack_nxt;
    logic         w_rd_en;

    assign w_rd_en   = (r_state == S_READ_ROW) && !stall;
    assign rd_en     = w_rd_en;
    assign input_col = r_col;
    assign input_row = r_row;
    assign next_row  = r_row_end;
    assign rst_addr  = r_row_end;
    assign row_ack   = r_row_ack;
    assign job_done  = r_job_done;
    assign busy      = r_busy;

    // Next-state and coordinate logic; abort overrides everything, including start.
    always_comb begin
        w_state_nxt    = r_state;
        w_num_cols_nxt = r_num_cols;
        w_num_rows_nxt = r_num_rows;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_row_ack_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_num_cols_nxt = num_cols;
                        w_num_rows_nxt = num_rows;
                        w_col_nxt      = '0;
                        w_row_nxt      = '0;
                        w_state_nxt    = S_WAIT_ROW;
                    end
                end
                S_WAIT_ROW: begin
                    // A cancelled fetch leaves row_avail pending for the next row.
                    if (cncl_fetch_req) begin
                        w_state_nxt = S_READ_ROW;
                    end else if (row_avail) begin
                        w_row_ack_nxt = 1'b1;
                        w_state_nxt   = S_READ_ROW;
                    end
                end
                S_READ_ROW: begin
                    if (w_rd_en) begin
                        if (r_col == r_num_cols) begin
                            w_state_nxt = S_ROW_END;
                        end else begin
                            w_col_nxt = r_col + ONE;
                        end
                    end
                end
                S_ROW_END: begin
                    w_col_nxt = '0;
                    if (r_row == r_num_rows) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_row_nxt   = r_row + ONE;
                        w_state_nxt = S_WAIT_ROW;
                    end
                end
                S_DONE: begin
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Status pulses are registered from the next state so they line up with it.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_num_cols <= '0;
            r_num_rows <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_end  <= 1'b0;
            r_row_ack  <= 1'b0;
            r_job_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_num_cols <= w_num_cols_nxt;
            r_num_rows <= w_num_rows_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_row_end  <= (w_state_nxt == S_ROW_END);
            r_row_ack  <= w_row_ack_nxt;
            r_job_done <= (w_state_nxt == S_DONE);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_pfb_rd_seq.sv
// Directed bench for the prefetch-buffer read sequencer: raster walk, pad rows,
// back-pressure, degenerate sizes, abort, start-while-busy and mid-job reset.
module tb_cnn_layer_accel_pfb_rd_seq;

   logic       rd_clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [9:0] numCols = '0;
   logic [9:0] numRows = '0;
   logic       rowAvail = 1'b0;
   logic       cnclFetch = 1'b0;
   logic       stall = 1'b0;
   logic       abort = 1'b0;
   logic       rdEn;
   logic [9:0] inputCol;
   logic [9:0] inputRow;
   logic       nextRow;
   logic       rstAddr;
   logic       rowAck;
   logic       jobDone;
   logic       busy;

   int testCount = 0;
   int failCount = 0;

   int rdCount = 0;
   int nextRowCount = 0;
   int rstAddrCount = 0;
   int rowAckCount = 0;
   int jobDoneCount = 0;
   int busyCount = 0;
   logic [9:0] rdCols[$];

   int snapRd, snapNext, snapRstAddr, snapAck, snapJob, snapBusy, snapIdx;
   bit found;

   // Back-pressure walk, one entry per cycle from the first READ_ROW cycle onward.
   int stallV[15]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
   int expRd[15]   = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0};
   int expCol[15]  = '{0, 1, 1, 1, 2, 3, 3, 0, 0, 1, 2, 3, 3, 3, 0};
   int expNext[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

   cnn_layer_accel_pfb_rd_seq #(.C_CLG2_ROW_BUF_BRAM_DEPTH(10)) dut (
      .rd_clk         (rd_clk),
      .rst            (rst),
      .start          (start),
      .num_cols       (numCols),
      .num_rows       (numRows),
      .row_avail      (rowAvail),
      .cncl_fetch_req (cnclFetch),
      .stall          (stall),
      .abort          (abort),
      .rd_en          (rdEn),
      .input_col      (inputCol),
      .input_row      (inputRow),
      .next_row       (nextRow),
      .rst_addr       (rstAddr),
      .row_ack        (rowAck),
      .job_done       (jobDone),
      .busy           (busy)
   );

   // Free-running read clock.
   always #5 rd_clk = ~rd_clk;

   // Event counters sampled mid-cycle, well clear of the rising edge.
   always @(negedge rd_clk) begin
      #2;
      if (rdEn) begin
         rdCount++;
         rdCols.push_back(inputCol);
      end
      if (nextRow) nextRowCount++;
      if (rstAddr) rstAddrCount++;
      if (rowAck) rowAckCount++;
      if (jobDone) jobDoneCount++;
      if (busy) busyCount++;
   end

   // Hard stop in case the bench itself wedges.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(negedge rd_clk);
   endtask

   task automatic takeSnapshot;
      snapRd      = rdCount;
      snapNext    = nextRowCount;
      snapRstAddr = rstAddrCount;
      snapAck     = rowAckCount;
      snapJob     = jobDoneCount;
      snapBusy    = busyCount;
      snapIdx     = rdCols.size();
   endtask

   // Row pacing per mode: 0 row_avail held, 1 pad rows 0/3, 2 cancel and row_avail together on row 0.
   task automatic driveRowInputs(input int mode);
      case (mode)
         1: begin
            cnclFetch = busy && (inputRow == 10'd0 || inputRow == 10'd3);
            rowAvail  = busy && (inputRow == 10'd1 || inputRow == 10'd2);
         end
         2: begin
            cnclFetch = busy && (inputRow == 10'd0);
            rowAvail  = 1'b1;
         end
         default: begin
            cnclFetch = 1'b0;
            rowAvail  = 1'b1;
         end
      endcase
   endtask

   task automatic applyStimulus(input logic [9:0] cols, input logic [9:0] rows, input int mode);
      bit done;
      done = 1'b0;
      tick;
      numCols = cols;
      numRows = rows;
      start   = 1'b1;
      driveRowInputs(mode);
      for (int i = 0; i < 400 && !done; i++) begin
         tick;
         start = 1'b0;
         driveRowInputs(mode);
         #1;
         if (jobDone) done = 1'b1;
      end
      checkOutput("jobDoneSeen", int'(done), 1);
      tick;
      rowAvail  = 1'b0;
      cnclFetch = 1'b0;
      tick;
   endtask

   initial begin
      // Reset values
      repeat (3) tick;
      #1;
      checkOutput("rst.rd_en", int'(rdEn), 0);
      checkOutput("rst.input_col", int'(inputCol), 0);
      checkOutput("rst.input_row", int'(inputRow), 0);
      checkOutput("rst.pulses", int'({nextRow, rstAddr, rowAck, jobDone}), 0);
      checkOutput("rst.busy", int'(busy), 0);
      tick;
      rst = 1'b0;
      tick;

      // Plain walk
      takeSnapshot();
      applyStimulus(10'd3, 10'd1, 0);
      checkOutput("plain.rd_en", rdCount - snapRd, 8);
      checkOutput("plain.next_row", nextRowCount - snapNext, 2);
      checkOutput("plain.rst_addr", rstAddrCount - snapRstAddr, 2);
      checkOutput("plain.row_ack", rowAckCount - snapAck, 2);
      checkOutput("plain.job_done", jobDoneCount - snapJob, 1);
      for (int k = 0; k < 8; k++) begin
         if (snapIdx + k < rdCols.size())
            checkOutput($sformatf("plain.col%0d", k), int'(rdCols[snapIdx + k]), k % 4);
         else
            checkOutput($sformatf("plain.col%0d.missing", k), 0, 1);
      end

      // Padding / upsample rows
      takeSnapshot();
      applyStimulus(10'd5, 10'd3, 1);
      checkOutput("pad.rd_en", rdCount - snapRd, 24);
      checkOutput("pad.row_ack", rowAckCount - snapAck, 2);
      checkOutput("pad.next_row", nextRowCount - snapNext, 4);
      checkOutput("pad.job_done", jobDoneCount - snapJob, 1);

      // Cancel has priority over a simultaneous row_avail
      takeSnapshot();
      applyStimulus(10'd0, 10'd1, 2);
      checkOutput("prio.row_ack", rowAckCount - snapAck, 1);
      checkOutput("prio.rd_en", rdCount - snapRd, 2);

      // Back-pressure, including a stall on the last column of the second row
      tick;
      numCols  = 10'd3;
      numRows  = 10'd1;
      start    = 1'b1;
      rowAvail = 1'b1;
      stall    = 1'b0;
      tick;
      start = 1'b0;
      #1;
      checkOutput("bp.wait.busy", int'(busy), 1);
      checkOutput("bp.wait.rd_en", int'(rdEn), 0);
      for (int j = 0; j < 15; j++) begin
         tick;
         stall = stallV[j][0];
         #1;
         checkOutput($sformatf("bp%0d.rd_en", j), int'(rdEn), expRd[j]);
         checkOutput($sformatf("bp%0d.col", j), int'(inputCol), expCol[j]);
         checkOutput($sformatf("bp%0d.next_row", j), int'(nextRow), expNext[j]);
         checkOutput($sformatf("bp%0d.rst_addr", j), int'(rstAddr), expNext[j]);
         if (j == 14) checkOutput("bp.job_done", int'(jobDone), 1);
      end
      tick;
      stall    = 1'b0;
      rowAvail = 1'b0;
      #1;
      checkOutput("bp.idle.busy", int'(busy), 0);

      // Degenerate sizes
      takeSnapshot();
      applyStimulus(10'd0, 10'd0, 0);
      checkOutput("deg.rd_en", rdCount - snapRd, 1);
      checkOutput("deg.next_row", nextRowCount - snapNext, 1);
      checkOutput("deg.job_done", jobDoneCount - snapJob, 1);
      checkOutput("deg.busy_cycles", busyCount - snapBusy, 4);

      // Abort mid-row
      tick;
      numCols  = 10'd7;
      numRows  = 10'd1;
      start    = 1'b1;
      rowAvail = 1'b1;
      found    = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick;
         start = 1'b0;
         #1;
         if (inputRow == 10'd1 && inputCol == 10'd4 && rdEn) found = 1'b1;
      end
      checkOutput("abort.reached", int'(found), 1);
      abort = 1'b1;
      takeSnapshot();
      tick;
      abort = 1'b0;
      #1;
      checkOutput("abort.busy", int'(busy), 0);
      checkOutput("abort.input_col", int'(inputCol), 0);
      checkOutput("abort.input_row", int'(inputRow), 0);
      repeat (4) tick;
      checkOutput("abort.next_row", nextRowCount - snapNext, 0);
      checkOutput("abort.job_done", jobDoneCount - snapJob, 0);
      rowAvail = 1'b0;
      takeSnapshot();
      applyStimulus(10'd2, 10'd1, 0);
      checkOutput("postabort.rd_en", rdCount - snapRd, 6);
      checkOutput("postabort.next_row", nextRowCount - snapNext, 2);
      checkOutput("postabort.job_done", jobDoneCount - snapJob, 1);

      // Start while busy is ignored; reset in ROW_END clears everything
      tick;
      numCols  = 10'd3;
      numRows  = 10'd1;
      start    = 1'b1;
      rowAvail = 1'b1;
      tick;
      start = 1'b0;
      takeSnapshot();
      tick;
      start   = 1'b1;
      numCols = 10'd9;
      tick;
      start = 1'b0;
      found = 1'b0;
      #1;
      for (int i = 0; i < 50 && !found; i++) begin
         if (nextRow) found = 1'b1;
         else begin
            tick;
            #1;
         end
      end
      checkOutput("busystart.row_end", int'(found), 1);
      checkOutput("busystart.col_at_end", int'(inputCol), 3);
      checkOutput("busystart.rd_en", rdCount - snapRd, 4);
      rst = 1'b1;
      tick;
      #1;
      checkOutput("midrst.outputs", int'({rdEn, nextRow, rstAddr, rowAck, jobDone}), 0);
      checkOutput("midrst.input_col", int'(inputCol), 0);
      checkOutput("midrst.input_row", int'(inputRow), 0);
      checkOutput("midrst.busy", int'(busy), 0);
      tick;
      rst      = 1'b0;
      rowAvail = 1'b0;
      repeat (3) tick;
      checkOutput("midrst.job_done", jobDoneCount - snapJob, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
